// File: rtl/alu_branch_unit.sv
// Execute-stage datapath for a single-cycle RV32I core: ALU, flag subtractor,
// PC adders and branch/jump resolver, plus a registered status snapshot.
module alu_branch_unit #(
  parameter int unsigned PC_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  alu_control,
  input  logic [31:0] pc,
  input  logic [31:0] target_base,
  input  logic [31:0] imm,
  input  logic [5:0]  branch,
  input  logic        jump,
  output logic [31:0] alu_result,
  output logic [3:0]  flags,
  output logic [31:0] pc_plus,
  output logic [31:0] pc_target,
  output logic        pc_next_src,
  output logic [3:0]  flags_q,
  output logic        taken_q
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLL    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum int unsigned {
    BR_BEQ  = 0,
    BR_BNE  = 1,
    BR_BLT  = 2,
    BR_BGE  = 3,
    BR_BLTU = 4,
    BR_BGEU = 5
  } branch_idx_e;

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  logic [32:0] diff_full;
  logic [31:0] diff;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [4:0]  shamt;
  logic [5:0]  cond;

  // Flag subtractor is separate from the ALU so branches never depend on alu_control.
  assign diff_full = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
  assign diff      = diff_full[31:0];

  assign flag_n = diff[31];
  assign flag_z = (diff == 32'd0);
  assign flag_c = diff_full[32];
  assign flag_v = (src_a[31] != src_b[31]) & (diff[31] != src_a[31]);
  assign flags  = {flag_n, flag_z, flag_c, flag_v};

  assign lt_signed   = flag_n ^ flag_v;
  assign lt_unsigned = ~flag_c;
  assign shamt       = src_b[4:0];

  always_comb begin
    // NOTE: default assignment first so every path drives alu_result and no latch is inferred.
    alu_result = 32'd0;
    case (alu_op_e'(alu_control))
      ALU_ADD:    alu_result = src_a + src_b;
      ALU_SUB:    alu_result = diff;
      ALU_AND:    alu_result = src_a & src_b;
      ALU_OR:     alu_result = src_a | src_b;
      ALU_XOR:    alu_result = src_a ^ src_b;
      ALU_SLL:    alu_result = src_a << shamt;
      ALU_SRL:    alu_result = src_a >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(src_a) >>> shamt);
      ALU_SLT:    alu_result = {31'd0, lt_signed};
      ALU_SLTU:   alu_result = {31'd0, lt_unsigned};
      ALU_PASS_B: alu_result = src_b;
      default:    alu_result = 32'd0;
    endcase
  end

  always_comb begin
    cond          = '0;
    cond[BR_BEQ]  = flag_z;
    cond[BR_BNE]  = ~flag_z;
    cond[BR_BLT]  = lt_signed;
    cond[BR_BGE]  = ~lt_signed;
    cond[BR_BLTU] = lt_unsigned;
    cond[BR_BGEU] = ~lt_unsigned;
  end

  // Several set branch bits simply OR together; decode upstream guarantees one-hot.
  assign pc_next_src = jump | (|(branch & cond));

  assign pc_plus   = pc + PC_INC;
  assign pc_target = target_base + imm;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for registered state; reset is synchronous and wins.
    if (rst) begin
      flags_q <= 4'b0000;
      taken_q <= 1'b0;
    end else begin
      flags_q <= flags;
      taken_q <= pc_next_src;
    end
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed self-checking bench for alu_branch_unit with hand-computed vectors.
module tb_alu_branch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_control;
  logic [31:0] pc;
  logic [31:0] target_base;
  logic [31:0] imm;
  logic [5:0]  branch;
  logic        jump;
  logic [31:0] alu_result;
  logic [3:0]  flags;
  logic [31:0] pc_plus;
  logic [31:0] pc_target;
  logic        pc_next_src;
  logic [3:0]  flags_q;
  logic        taken_q;

  int total = 0;
  int bad   = 0;

  alu_branch_unit #(.PC_STEP(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .pc          (pc),
    .target_base (target_base),
    .imm         (imm),
    .branch      (branch),
    .jump        (jump),
    .alu_result  (alu_result),
    .flags       (flags),
    .pc_plus     (pc_plus),
    .pc_target   (pc_target),
    .pc_next_src (pc_next_src),
    .flags_q     (flags_q),
    .taken_q     (taken_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
    src_a = a;
    src_b = b;
    alu_control = ctl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    src_a = '0; src_b = '0; alu_control = '0;
    pc = '0; target_base = '0; imm = '0;
    branch = '0; jump = 1'b0;

    // Reset state: drive inputs that would otherwise load non-zero status.
    src_a = 32'd5; src_b = 32'd5; jump = 1'b1;
    @(posedge clk); #1;
    check("rst_flags_q", {28'd0, flags_q}, 32'h0);
    check("rst_taken_q", {31'd0, taken_q}, 32'h0);
    jump = 1'b0;
    rst = 1'b0;

    // ADD/SUB wrap and flags
    alu(32'hFFFF_FFFF, 32'd1, 4'b0000);
    check("add_wrap", alu_result, 32'h0);
    alu(32'hFFFF_FFFF, 32'd1, 4'b0001);
    check("sub_result", alu_result, 32'hFFFF_FFFE);
    check("sub_flags", {28'd0, flags}, 32'b1010);

    // Signed vs unsigned compare
    alu(32'hFFFF_FFFF, 32'd1, 4'b1000);
    check("slt", alu_result, 32'd1);
    alu(32'hFFFF_FFFF, 32'd1, 4'b1001);
    check("sltu", alu_result, 32'd0);
    branch = 6'b000100; #1;
    check("blt_neg1_1", {31'd0, pc_next_src}, 32'd1);
    branch = 6'b010000; #1;
    check("bltu_neg1_1", {31'd0, pc_next_src}, 32'd0);
    branch = 6'b100000; #1;
    check("bgeu_neg1_1", {31'd0, pc_next_src}, 32'd1);

    // Signed overflow: -2^31 - 1
    alu(32'h8000_0000, 32'd1, 4'b0001);
    check("ovf_flags", {28'd0, flags}, 32'b0011);
    branch = 6'b000100; #1;
    check("blt_ovf", {31'd0, pc_next_src}, 32'd1);
    branch = 6'b001000; #1;
    check("bge_ovf", {31'd0, pc_next_src}, 32'd0);
    branch = 6'b000000;

    // Shifts use b[4:0] only
    alu(32'h8000_0000, 32'h21, 4'b0111);
    check("sra", alu_result, 32'hC000_0000);
    alu(32'h8000_0000, 32'h21, 4'b0110);
    check("srl", alu_result, 32'h4000_0000);
    alu(32'h8000_0000, 32'h21, 4'b0101);
    check("sll", alu_result, 32'h0);
    alu(32'h0000_0003, 32'h24, 4'b0101);
    check("sll_4", alu_result, 32'h30);

    // Logic ops, pass-through and unused encodings
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b0000);
    check("add_mix", alu_result, 32'h00E0_1333);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b0010);
    check("and", alu_result, 32'h00F0_0034);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b0011);
    check("or", alu_result, 32'hFFF0_12FF);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b0100);
    check("xor", alu_result, 32'hFF00_12CB);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b1010);
    check("pass_b", alu_result, 32'h0FF0_00FF);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b1011);
    check("ctl_1011", alu_result, 32'h0);
    alu(32'hF0F0_1234, 32'h0FF0_00FF, 4'b1111);
    check("ctl_1111", alu_result, 32'h0);

    // Branch/jump resolution with a == b
    alu(32'd5, 32'd5, 4'b0000);
    check("eq_flags", {28'd0, flags}, 32'b0110);
    branch = 6'b000001; #1;
    check("beq_eq", {31'd0, pc_next_src}, 32'd1);
    branch = 6'b000010; #1;
    check("bne_eq", {31'd0, pc_next_src}, 32'd0);
    branch = 6'b000011; #1;
    check("beq_bne_or", {31'd0, pc_next_src}, 32'd1);
    branch = 6'b000000; jump = 1'b1; #1;
    check("jump", {31'd0, pc_next_src}, 32'd1);
    jump = 1'b0; #1;
    check("none", {31'd0, pc_next_src}, 32'd0);

    // PC adders
    pc = 32'h10; target_base = 32'h10; imm = 32'hFFFF_FFFC; #1;
    check("pc_target", pc_target, 32'h0C);
    check("pc_plus", pc_plus, 32'h11);
    pc = 32'hFFFF_FFFF; target_base = 32'h1000; imm = 32'h24; #1;
    check("pc_plus_wrap", pc_plus, 32'h0);
    check("pc_target_jalr", pc_target, 32'h1024);

    // Registered status after release of reset
    src_a = 32'd5; src_b = 32'd5; branch = 6'b000001; jump = 1'b0;
    @(posedge clk); #1;
    check("reg_flags_q", {28'd0, flags_q}, 32'b0110);
    check("reg_taken_q", {31'd0, taken_q}, 32'd1);

    // Registers track a new cycle's values
    src_a = 32'hFFFF_FFFF; src_b = 32'd1; branch = 6'b010000;
    @(posedge clk); #1;
    check("reg2_flags_q", {28'd0, flags_q}, 32'b1010);
    check("reg2_taken_q", {31'd0, taken_q}, 32'd0);

    // Mid-operation reset wins; combinational outputs unaffected
    src_a = 32'd5; src_b = 32'd5; branch = 6'b000001; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_flags_q", {28'd0, flags_q}, 32'h0);
    check("midrst_taken_q", {31'd0, taken_q}, 32'h0);
    check("midrst_comb", {31'd0, pc_next_src}, 32'd1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
